// File: rtl/serial_adder_pkg.sv
// Shared state type and sizing helpers for the serial digit adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int digit);
        return (digit < 1) ? 1 : width / digit;
    endfunction

    // A single-step adder still carries a 1-bit counter so the datapath stays uniform.
    function automatic int calc_cnt_w(input int width, input int digit);
        int steps;
        steps = calc_steps(width, digit);
        return (steps < 2) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_digit_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial digit adder.
// SERIAL_ADDER_SUB_EN adds the sub request and the signed overflow flag.
interface serial_digit_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
    logic             overflow;

    modport master (output start, x, y, carry_in, sub,
                    input  busy, done, sum, carry_out, overflow);
    modport slave  (input  start, x, y, carry_in, sub,
                    output busy, done, sum, carry_out, overflow);
`else
    modport master (output start, x, y, carry_in,
                    input  busy, done, sum, carry_out);
    modport slave  (input  start, x, y, carry_in,
                    output busy, done, sum, carry_out);
`endif
endinterface

// File: rtl/serial_digit_adder_ripple.sv
// Combinational ripple chain of DIGIT full-adder cells; also exposes the
// carry into the top bit so the caller can derive signed overflow.
module digit_ripple_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT:0] c_vec;

    always_comb begin
        c_vec    = '0;
        c_vec[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            c_vec[i+1] = (a[i] & b[i]) | (c_vec[i] & (a[i] ^ b[i]));
        end
    end

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
        assign s[gi] = a[gi] ^ b[gi] ^ c_vec[gi];
    end

    assign co    = c_vec[DIGIT];
    assign c_msb = c_vec[DIGIT-1];
endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder: DIGIT bits of x+y+carry_in per clock through one ripple digit.
// Define SERIAL_ADDER_SUB_EN for the subtract mode and the signed overflow output.
module serial_digit_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_digit_adder_if.slave bus
);
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
    end

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d, y_q, y_d, res_q, res_d, sum_q, sum_d;
    logic               carry_q, carry_d, cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT-1:0]   dsum;
    logic               dco;
    logic [WIDTH-1:0]   res_shift;
    logic [WIDTH-1:0]   y_cap;
    logic               c_cap;
    logic               accept;

    assign accept = bus.start && (state_q != RUN);

`ifdef SERIAL_ADDER_SUB_EN
    logic dc_msb;
    logic ovf_q, ovf_d;

    // Two's-complement subtract: x + ~y + 1.
    assign y_cap = bus.sub ? ~bus.y : bus.y;
    assign c_cap = bus.sub | bus.carry_in;

    digit_ripple_adder #(.DIGIT(DIGIT)) u_digit (
        .a(x_q[DIGIT-1:0]), .b(y_q[DIGIT-1:0]), .ci(carry_q),
        .s(dsum), .co(dco), .c_msb(dc_msb)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (!accept && state_q == RUN && cnt_q == LAST) ovf_d = dc_msb ^ dco;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign bus.overflow = ovf_q;
`else
    assign y_cap = bus.y;
    assign c_cap = bus.carry_in;

    digit_ripple_adder #(.DIGIT(DIGIT)) u_digit (
        .a(x_q[DIGIT-1:0]), .b(y_q[DIGIT-1:0]), .ci(carry_q),
        .s(dsum), .co(dco), .c_msb()
    );
`endif

    // Result fills from the top, so after STEPS shifts digit 0 sits at the LSB.
    if (DIGIT == WIDTH) begin : g_one_digit
        assign res_shift = dsum;
    end else begin : g_multi_digit
        assign res_shift = {dsum, res_q[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        if (accept) begin
            x_d     = bus.x;
            y_d     = y_cap;
            carry_d = c_cap;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            x_d     = x_q >> DIGIT;
            y_d     = y_q >> DIGIT;
            res_d   = res_shift;
            carry_d = dco;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                sum_d  = res_shift;
                cout_d = dco;
            end
        end
    end

    always_comb begin
        bus.busy      = (state_q == RUN);
        bus.done      = (state_q == DONE);
        bus.sum       = sum_q;
        bus.carry_out = cout_q;
    end
endmodule

// File: tb/tb_serial_digit_adder.sv
// Scoreboard bench: one 16/4 adder for handshake scenarios, four 8-bit adders
// (DIGIT 1,2,4,8) sharing stimulus for latency and random arithmetic.
module tb_serial_digit_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp16_q [$];
    logic [9:0]  exp8_q  [$];

    serial_digit_adder_if #(.WIDTH(16)) bus16 ();
    serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    logic       start8, cin8, sub8;
    logic [7:0] x8, y8;
    logic [3:0] done8, busy8, cout8, ovf8;
    logic [7:0] sum8 [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_w8
        serial_digit_adder_if #(.WIDTH(8)) bus8 ();
        assign bus8.start    = start8;
        assign bus8.x        = x8;
        assign bus8.y        = y8;
        assign bus8.carry_in = cin8;
        assign done8[gi]     = bus8.done;
        assign busy8[gi]     = bus8.busy;
        assign cout8[gi]     = bus8.carry_out;
        assign sum8[gi]      = bus8.sum;
`ifdef SERIAL_ADDER_SUB_EN
        assign bus8.sub      = sub8;
        assign ovf8[gi]      = bus8.overflow;
`else
        assign ovf8[gi]      = 1'b0;
`endif
        serial_digit_adder #(.WIDTH(8), .DIGIT(1 << gi)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    end

    // Reference: subtract as x + ~y + 1, overflow from operand/result sign rule.
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic ci, input logic s);
        logic [7:0] bb;
        logic [8:0] r;
        logic       ov;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {8'd0, (s | ci)};
        ov = (a[7] == bb[7]) && (r[7] != a[7]);
        return {ov, r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus16.start = 1'b0; bus16.x = '0; bus16.y = '0; bus16.carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus16.sub = 1'b0;
`endif
        start8 = 1'b0; x8 = '0; y8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        #12;
        checks++;
        if ({bus16.busy, bus16.done, bus16.carry_out} !== 3'b000 || bus16.sum !== 16'h0) begin
            errors++;
            $display("FAIL reset16: busy=%b done=%b sum=%h cout=%b, want all zero",
                     bus16.busy, bus16.done, bus16.sum, bus16.carry_out);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy8[i] !== 1'b0 || done8[i] !== 1'b0 || sum8[i] !== 8'h0 || cout8[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset8[%0d]: busy=%b done=%b sum=%h cout=%b, want all zero",
                         i, busy8[i], done8[i], sum8[i], cout8[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add16();
        logic [16:0] exp;
        int          cyc;
        @(negedge clk);
        bus16.x = 16'h1234; bus16.y = 16'h0FCC; bus16.carry_in = 1'b1; bus16.start = 1'b1;
        exp16_q.push_back({1'b0, 16'h1234} + {1'b0, 16'h0FCC} + 17'd1);
        @(negedge clk);
        bus16.start = 1'b0; bus16.x = '0; bus16.y = '0; bus16.carry_in = 1'b0;
        cyc = 1;
        while (bus16.done !== 1'b1 && cyc < 20) begin
            checks++;
            if (bus16.busy !== 1'b1) begin
                errors++; $display("FAIL add16_busy: cycle %0d busy=%b, want 1", cyc, bus16.busy);
            end
            checks++;
            if (bus16.sum !== 16'h0 || bus16.carry_out !== 1'b0) begin
                errors++; $display("FAIL add16_hold: cycle %0d sum=%h cout=%b, want 0000/0", cyc, bus16.sum, bus16.carry_out);
            end
            @(negedge clk); cyc++;
        end
        checks++;
        if (bus16.done !== 1'b1) begin
            errors++; $display("FAIL add16_timeout: no done within %0d cycles", cyc);
        end else begin
            exp = exp16_q.pop_front();
            checks++;
            if (cyc != 5) begin
                errors++; $display("FAIL add16_latency: done at cycle %0d, want 5", cyc);
            end
            checks++;
            if ({bus16.carry_out, bus16.sum} !== exp) begin
                errors++; $display("FAIL add16_result: got %h, want %h", {bus16.carry_out, bus16.sum}, exp);
            end
            checks++;
            if (bus16.busy !== 1'b0) begin
                errors++; $display("FAIL add16_busy_done: busy=%b during done, want 0", bus16.busy);
            end
            $display("W16 add: x=1234 y=0fcc cin=1 -> cout,sum=%h at cycle %0d", {bus16.carry_out, bus16.sum}, cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [2];
        logic [15:0] ys [2];
        logic [15:0] held [2];
        logic [16:0] exp;
        int          cyc;
        xs[0] = 16'h1111; ys[0] = 16'h2222; held[0] = 16'h2201;
        xs[1] = 16'h0003; ys[1] = 16'h0004; held[1] = 16'h3333;
        @(negedge clk);
        bus16.x = xs[0]; bus16.y = ys[0]; bus16.carry_in = 1'b0; bus16.start = 1'b1;
        exp16_q.push_back({1'b0, xs[0]} + {1'b0, ys[0]});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus16.start = 1'b0;
            cyc = 1;
            while (bus16.done !== 1'b1 && cyc < 20) begin
                checks++;
                if (bus16.busy !== 1'b1 || bus16.sum !== held[k]) begin
                    errors++;
                    $display("FAIL b2b_run%0d: cycle %0d busy=%b sum=%h, want 1/%h", k, cyc, bus16.busy, bus16.sum, held[k]);
                end
                if (k == 0 && cyc == 2) begin
                    bus16.start = 1'b1; bus16.x = 16'hFFFF; bus16.y = 16'hFFFF; bus16.carry_in = 1'b1;
                end
                if (k == 0 && cyc == 3) bus16.start = 1'b0;
                @(negedge clk); cyc++;
            end
            checks++;
            if (bus16.done !== 1'b1) begin
                errors++; $display("FAIL b2b_timeout%0d: no done within %0d cycles", k, cyc);
            end else begin
                exp = exp16_q.pop_front();
                checks++;
                if (cyc != 5) begin
                    errors++; $display("FAIL b2b_latency%0d: done at cycle %0d, want 5", k, cyc);
                end
                checks++;
                if ({bus16.carry_out, bus16.sum} !== exp) begin
                    errors++; $display("FAIL b2b_result%0d: got %h, want %h", k, {bus16.carry_out, bus16.sum}, exp);
                end
                $display("W16 b2b %0d: cout,sum=%h at cycle %0d", k, {bus16.carry_out, bus16.sum}, cyc);
            end
            if (k == 0) begin
                bus16.x = xs[1]; bus16.y = ys[1]; bus16.carry_in = 1'b0; bus16.start = 1'b1;
                exp16_q.push_back({1'b0, xs[1]} + {1'b0, ys[1]});
            end
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        bus16.x = 16'h0F0F; bus16.y = 16'h0101; bus16.carry_in = 1'b1; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus16.busy, bus16.done, bus16.carry_out} !== 3'b000 || bus16.sum !== 16'h0) begin
            errors++;
            $display("FAIL midreset: busy=%b done=%b sum=%h cout=%b, want all zero",
                     bus16.busy, bus16.done, bus16.sum, bus16.carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus16.done !== 1'b0 || bus16.busy !== 1'b0) begin
                errors++; $display("FAIL midreset_idle: cycle %0d done=%b busy=%b, want 0/0", i, bus16.done, bus16.busy);
            end
        end
        $display("W16 reset mid-run: aborted, idle afterwards");
    endtask

    task automatic test_digit_configs();
`ifdef SERIAL_ADDER_SUB_EN
        localparam int NDIR = 4;
`else
        localparam int NDIR = 2;
`endif
        logic [7:0] dx [4];
        logic [7:0] dy [4];
        logic       ds [4];
        logic [9:0] exp;
        logic [3:0] pending;
        int         cyc;
        dx[0] = 8'hFF; dy[0] = 8'h01; ds[0] = 1'b0;
        dx[1] = 8'h80; dy[1] = 8'h80; ds[1] = 1'b0;
        dx[2] = 8'h05; dy[2] = 8'h07; ds[2] = 1'b1;
        dx[3] = 8'h80; dy[3] = 8'h01; ds[3] = 1'b1;
        for (int n = 0; n < NDIR + 1000; n++) begin
            @(negedge clk);
            if (n < NDIR) begin
                x8 = dx[n]; y8 = dy[n]; cin8 = 1'b0; sub8 = ds[n];
            end else begin
                x8 = 8'($urandom_range(0, 255));
                y8 = 8'($urandom_range(0, 255));
                cin8 = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
                sub8 = 1'($urandom_range(0, 1));
`endif
            end
            exp8_q.push_back(model8(x8, y8, cin8, sub8));
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            x8 = ~x8;
            cyc = 1;
            pending = 4'hF;
            exp = exp8_q[0];
            while (pending != 4'h0 && cyc <= 12) begin
                for (int i = 0; i < 4; i++) begin
                    if (pending[i]) begin
                        if (done8[i] === 1'b1) begin
                            checks++;
                            if (cyc != (8 >> i) + 1) begin
                                errors++; $display("FAIL w8_latency[D=%0d] vec %0d: done at cycle %0d, want %0d", 1 << i, n, cyc, (8 >> i) + 1);
                            end
                            checks++;
                            if ({cout8[i], sum8[i]} !== exp[8:0]) begin
                                errors++; $display("FAIL w8_result[D=%0d] vec %0d: got %h, want %h", 1 << i, n, {cout8[i], sum8[i]}, exp[8:0]);
                            end
`ifdef SERIAL_ADDER_SUB_EN
                            checks++;
                            if (ovf8[i] !== exp[9]) begin
                                errors++; $display("FAIL w8_overflow[D=%0d] vec %0d: got %b, want %b", 1 << i, n, ovf8[i], exp[9]);
                            end
`endif
                            pending[i] = 1'b0;
                        end else begin
                            checks++;
                            if (busy8[i] !== 1'b1) begin
                                errors++; $display("FAIL w8_busy[D=%0d] vec %0d: cycle %0d busy=%b, want 1", 1 << i, n, cyc, busy8[i]);
                            end
                        end
                    end
                end
                if (pending != 4'h0) begin
                    @(negedge clk); cyc++;
                end
            end
            if (pending != 4'h0) begin
                checks++; errors++;
                $display("FAIL w8_timeout vec %0d: pending=%b after %0d cycles", n, pending, cyc);
            end
            exp = exp8_q.pop_front();
            $display("W8 vec %0d: sub=%b cin=%b -> exp ovf,cout,sum=%h", n, sub8, cin8, exp);
        end
    endtask

    initial begin
        test_reset();
        test_add16();
        test_back_to_back();
        test_reset_mid_run();
        test_digit_configs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_digit_adder.md
Name: serial_digit_adder

Overview:
- Multi-cycle, parametrised successor to the team's single-bit full-adder cell.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using one registered carry between steps.
- Trades latency for area. Sits beside the board-demo arithmetic blocks, driven by switch/button logic and read by the seven-segment/LED display paths.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be ≥1 and a multiple of DIGIT; elaboration fails otherwise.
- DIGIT, 4: bits added per clock cycle. Range 1..WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- x  in  WIDTH  operand X, captured on accepted start.
- y  in  WIDTH  operand Y, captured on accepted start.
- carry_in  in  1  initial carry, captured on accepted start.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse when sum/carry_out become valid.
- sum  out  WIDTH  result, held until the next accepted start completes.
- carry_out  out  1  final carry, held like sum.

Behaviour:
- Reset: rst_n low asynchronously clears all state. busy=0, done=0, sum=0, carry_out=0, state=IDLE, step counter=0.
- State machine states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch x and y into shift registers and carry_in into the carry register.
  - Clear the counter.
  - Go to RUN; busy=1 on the next cycle.
- RUN, each cycle:
  - Add the low DIGIT bits of X, the low DIGIT bits of Y, and the carry register.
  - Shift X and Y right by DIGIT.
  - Shift the DIGIT-bit digit sum into the top of the result register.
  - Store the digit carry.
  - Increment the counter.
  - When the counter reaches STEPS-1 (STEPS = WIDTH/DIGIT), go to DONE on that edge.
- DONE, for one cycle:
  - done=1, busy=0.
  - sum = result register; carry_out = carry register.
  - Next state IDLE, or RUN if start=1 in this cycle (back-to-back acceptance).
- Latency: done is asserted STEPS+1 cycles after the accepting edge.
  - DIGIT=WIDTH gives 2 cycles.
  - WIDTH=16, DIGIT=4 gives 5 cycles.
- start while busy=1 is ignored. Operand changes while busy do not affect the result.
- sum/carry_out keep their previous values during RUN. They update only on the edge entering DONE.
- Arithmetic: {carry_out,sum} = x + y + carry_in, exact modulo 2^(WIDTH+1). Unsigned; no saturation.
- Reset mid-RUN: operation aborted, outputs zeroed, no done pulse.
- Counter width: $clog2(STEPS), minimum 1 bit. STEPS=1 goes straight from RUN to DONE after one step.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- When defined:
  - Extra input port sub (1 bit), captured on start.
  - sub=1: Y is inverted on capture and the initial carry is forced to 1, so the result is x - y. carry_out=1 means no borrow.
  - Extra output overflow (1 bit, reset 0, updated with sum): signed overflow = carry into MSB XOR carry out of MSB.
- When undefined: no sub or overflow ports; add only, behaviour exactly as above.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state enum (IDLE, RUN, DONE) as a typedef;
  - localparam function for STEPS and counter width.
- One sub-module, digit_ripple_adder (parameter DIGIT): purely combinational ripple chain of DIGIT full-adder cells.
  - Inputs a[DIGIT], b[DIGIT], ci.
  - Outputs s[DIGIT], co, and c_msb (carry into the top bit, for overflow).
  - Instantiated once in the datapath.

Test Plan:
- WIDTH=8, DIGIT=1: x=0xFF, y=0x01, carry_in=0, start 1 cycle → done at cycle 9 after accept; sum=0x00, carry_out=1; busy high cycles 1..8.
- WIDTH=16, DIGIT=4: x=0x1234, y=0x0FCC, carry_in=1 → done after 5 cycles; sum=0x2201, carry_out=0; sum unchanged during RUN.
- Back-to-back: start held high through DONE with new x=0x0003, y=0x0004 → second done exactly 5 cycles after the first; sum=0x0007. start pulses during busy are ignored.
- Reset mid-operation: assert rst_n=0 at RUN step 2 → busy, done, sum and carry_out are 0 immediately with no clock. After release, no done pulse until a new start.
- DIGIT=WIDTH=8: x=0x80, y=0x80 → done 2 cycles after accept; sum=0x00, carry_out=1. Random 1000-vector compare against x+y+cin for DIGIT in {1,2,4,8}.
- SERIAL_ADDER_SUB_EN, WIDTH=8: sub=1, x=0x05, y=0x07 → sum=0xFE, carry_out=0, overflow=0. sub=1, x=0x80, y=0x01 → sum=0x7F, overflow=1.
